// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward selects, PC register tag, shadow stage tag.
// Types and constants only, so there is no latency and no backpressure.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_e;

   localparam logic [3:0] REG_PC = 4'hF;

   typedef struct packed {
      logic [3:0] ra1;
      logic [3:0] ra2;
      logic [3:0] wa3;
      logic       reg_write;
      logic       mem_to_reg;
      logic       pc_src;
   } hz_tag_t;

   // The PC reads as PC+8 straight from the datapath, so it is never bypassed.
   function automatic fwd_sel_e fwd_sel(input logic [3:0] src, input hz_tag_t m, input hz_tag_t w);
      fwd_sel_e sel;
      sel = FWD_RF;
      if (src != REG_PC) begin
         if (m.reg_write && (m.wa3 == src))
            sel = FWD_M;
         else if (w.reg_write && (w.wa3 == src))
            sel = FWD_W;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_tag_reg.sv
// One shadow pipeline stage: async reset, synchronous clear wins over hold.
// Latency: one clock. No backpressure; the hold input freezes the stage.
module hazard_tag_reg
   import hazard_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    clr,
   input  logic    hold,
   input  hz_tag_t d,
   output hz_tag_t q
);

   hz_tag_t tag_d, tag_q;

   always_comb begin
      tag_d = tag_q;
      if (clr)
         tag_d = '0;
      else if (!hold)
         tag_d = d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tag_q <= '0;
      else
         tag_q <= tag_d;
   end

   assign q = tag_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/flush/forward from decode fields and shadow E/M/W tags, plus a stall counter.
// Latency: controls are combinational; shadow tags and the counter update every clock. No backpressure.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       RA1D,
   input  logic [3:0]       RA2D,
   input  logic [3:0]       WA3D,
   input  logic             RegWriteD,
   input  logic             MemtoRegD,
   input  logic             PCSrcD,
   input  logic             CondExE,
   input  logic             BranchTakenE,
   input  logic             ClrCount,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic [CNT_W-1:0] StallCount
);

   hz_tag_t tag_d, tag_e, tag_m_in, tag_m, tag_w;
   logic    ldr_stall, pc_pend;
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

   always_comb begin
      tag_d = '{ra1: RA1D, ra2: RA2D, wa3: WA3D,
                reg_write: RegWriteD, mem_to_reg: MemtoRegD, pc_src: PCSrcD};
      tag_m_in = tag_e;
      tag_m_in.reg_write = tag_e.reg_write & CondExE;
      tag_m_in.pc_src    = tag_e.pc_src & CondExE;
   end

   // A flush on the D->E register overrides the decode hold.
   hazard_tag_reg u_tag_e (
      .clk (clk), .rst (reset), .clr (FlushE), .hold (StallD & ~FlushE), .d (tag_d), .q (tag_e)
   );
   hazard_tag_reg u_tag_m (
      .clk (clk), .rst (reset), .clr (1'b0), .hold (1'b0), .d (tag_m_in), .q (tag_m)
   );
   hazard_tag_reg u_tag_w (
      .clk (clk), .rst (reset), .clr (1'b0), .hold (1'b0), .d (tag_m), .q (tag_w)
   );

   always_comb begin
      ldr_stall = tag_e.mem_to_reg & tag_e.reg_write &
                  ((RA1D == tag_e.wa3) | (RA2D == tag_e.wa3));
      pc_pend   = PCSrcD | tag_e.pc_src | tag_m.pc_src;
      StallF    = ldr_stall | pc_pend;
      StallD    = ldr_stall;
      FlushD    = pc_pend | tag_w.pc_src | BranchTakenE;
      FlushE    = ldr_stall | BranchTakenE;
      ForwardAE = fwd_sel(tag_e.ra1, tag_m, tag_w);
      ForwardBE = fwd_sel(tag_e.ra2, tag_m, tag_w);
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (ClrCount)
         stall_cnt_d = '0;
      else if (StallF && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign StallCount = stall_cnt_q;

endmodule
